// File: rtl/alu_wb_stage.sv
// Writeback/status stage behind RF_plus_ALU: 2-entry skid FIFO of ALU results, one commit
// per cycle to the register-file write port and the Z/N/C/V flags. Optional macro ALU_WB_FWD_EN.
module alu_wb_stage (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_y,
  input  logic        in_z,
  input  logic        in_n,
  input  logic        in_c,
  input  logic        in_v,
  input  logic [2:0]  in_dest,
  input  logic        in_wr_en,
  input  logic        in_flag_en,
  input  logic        wb_hold,
  output logic [15:0] Write_Data,
  output logic [2:0]  Write_Addr,
  output logic        Write_En,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic        flag_v,
  output logic        Pre_C,
  input  logic [2:0]  fwd_addr_a,
  input  logic [2:0]  fwd_addr_b,
  output logic        fwd_hit_a,
  output logic        fwd_hit_b,
  output logic [15:0] fwd_data_a,
  output logic [15:0] fwd_data_b
);

  typedef struct packed {
    logic [15:0] y;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic [2:0]  dest;
    logic        wr_en;
    logic        flag_en;
  } entry_t;

  entry_t      r_ent [2];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;
  logic        r_flag_z;
  logic        r_flag_n;
  logic        r_flag_c;
  logic        r_flag_v;

  entry_t      w_in_ent;
  entry_t      w_head;
  logic        w_accept;
  logic        w_commit;

  assign w_in_ent = '{y: in_y, z: in_z, n: in_n, c: in_c, v: in_v,
                      dest: in_dest, wr_en: in_wr_en, flag_en: in_flag_en};
  assign w_head   = r_ent[r_head];
  assign in_ready = !clr && (r_count != 2'd2);
  assign w_accept = in_valid && in_ready;
  assign w_commit = (r_count != 2'd0) && !wb_hold && !clr;

  // Entry storage: written at the tail on accept
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ent[0] <= '0;
      r_ent[1] <= '0;
    end else if (w_accept) begin
      r_ent[r_tail] <= w_in_ent;
    end else begin
      r_ent[r_tail] <= r_ent[r_tail];
    end
  end

  // Pointers and occupancy; simultaneous accept and commit leaves count unchanged
  always_ff @(posedge clk) begin
    if (clr) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_accept) r_tail <= ~r_tail;
      if (w_commit) r_head <= ~r_head;
      case ({w_accept, w_commit})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags load all four bits from a committing flag-enabled head
  always_ff @(posedge clk) begin
    if (clr) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_commit && w_head.flag_en) begin
      r_flag_z <= w_head.z;
      r_flag_n <= w_head.n;
      r_flag_c <= w_head.c;
      r_flag_v <= w_head.v;
    end else begin
      r_flag_z <= r_flag_z;
      r_flag_n <= r_flag_n;
      r_flag_c <= r_flag_c;
      r_flag_v <= r_flag_v;
    end
  end

  assign Write_En   = w_commit && w_head.wr_en;
  assign Write_Data = (r_count != 2'd0) ? w_head.y : 16'd0;
  assign Write_Addr = (r_count != 2'd0) ? w_head.dest : 3'd0;
  assign flag_z     = r_flag_z;
  assign flag_n     = r_flag_n;
  assign flag_c     = r_flag_c;
  assign flag_v     = r_flag_v;
  assign Pre_C      = r_flag_c;

`ifdef ALU_WB_FWD_EN
  entry_t w_young;
  logic   w_two;

  // With two entries the youngest sits opposite the head; a committing head is still pending
  assign w_two   = (r_count == 2'd2);
  assign w_young = r_ent[w_two ? ~r_head : r_head];

  // Forward lookup for both read ports, youngest match first
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = 16'd0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = 16'd0;
    if (!clr && (r_count != 2'd0)) begin
      if (w_young.wr_en && (w_young.dest == fwd_addr_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = w_young.y;
      end else if (w_two && w_head.wr_en && (w_head.dest == fwd_addr_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = w_head.y;
      end else begin
        fwd_hit_a  = 1'b0;
      end
      if (w_young.wr_en && (w_young.dest == fwd_addr_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = w_young.y;
      end else if (w_two && w_head.wr_en && (w_head.dest == fwd_addr_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = w_head.y;
      end else begin
        fwd_hit_b  = 1'b0;
      end
    end else begin
      fwd_hit_a = 1'b0;
      fwd_hit_b = 1'b0;
    end
  end
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{fwd_addr_a, fwd_addr_b};
  assign fwd_hit_a    = 1'b0;
  assign fwd_hit_b    = 1'b0;
  assign fwd_data_a   = 16'd0;
  assign fwd_data_b   = 16'd0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed scoreboard bench for alu_wb_stage; forwarding expectations follow ALU_WB_FWD_EN.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y;
  logic        in_z, in_n, in_c, in_v;
  logic [2:0]  in_dest;
  logic        in_wr_en, in_flag_en;
  logic        wb_hold;
  logic [15:0] Write_Data;
  logic [2:0]  Write_Addr;
  logic        Write_En;
  logic        flag_z, flag_n, flag_c, flag_v, Pre_C;
  logic [2:0]  fwd_addr_a, fwd_addr_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [15:0] fwd_data_a, fwd_data_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [18:0] sb [$];

  alu_wb_stage dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_v(in_v),
    .in_dest(in_dest), .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
    .wb_hold(wb_hold), .Write_Data(Write_Data), .Write_Addr(Write_Addr),
    .Write_En(Write_En), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .Pre_C(Pre_C), .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_data_a(fwd_data_a),
    .fwd_data_b(fwd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one entry; expected writes are queued in offer order
  task automatic put(input logic [15:0] y, input logic [2:0] dest, input logic wr,
                     input logic fl, input logic z, input logic n, input logic c, input logic v);
    in_valid = 1'b1; in_y = y; in_dest = dest; in_wr_en = wr; in_flag_en = fl;
    in_z = z; in_n = n; in_c = c; in_v = v;
    if (wr) sb.push_back({dest, y});
  endtask

  // Mid-cycle write-port check against the scoreboard, then advance to just after the edge
  task automatic tick();
    logic [18:0] e;
    @(negedge clk);
    if (Write_En) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'({Write_Addr, Write_Data}), 32'h7ffff);
      end else begin
        e = sb.pop_front();
        chk("wb_port", 32'({Write_Addr, Write_Data}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_y = 16'd0; in_z = 1'b0; in_n = 1'b0; in_c = 1'b0;
    in_v = 1'b0; in_dest = 3'd0; in_wr_en = 1'b0; in_flag_en = 1'b0; wb_hold = 1'b0;
    fwd_addr_a = 3'd0; fwd_addr_b = 3'd0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("rst_outputs", 32'({Write_En, Write_Addr, Write_Data, flag_z, flag_n, flag_c, flag_v,
        Pre_C, fwd_hit_a, fwd_hit_b}), 32'd0);
    chk("rst_in_ready_held", 32'(in_ready), 32'd0);
    clr = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // single entry: written the cycle after accept
    put(16'h3579, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("single_latency", 32'(sb.size()), 32'd0);
    chk("single_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);

    // carry feedback with a non-writing entry
    put(16'h0000, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("prec_before_commit", 32'(Pre_C), 32'd0);
    tick();
    chk("carry_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b1010);
    chk("carry_prec", 32'(Pre_C), 32'd1);

    // back-pressure: two accepts under hold, third waits
    wb_hold = 1'b1;
    put(16'h1111, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    put(16'h2222, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    tick();
    put(16'h3333, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_no_write", 32'(Write_En), 32'd0);
    tick();
    chk("bp_ready_held", 32'(in_ready), 32'd0);
    wb_hold = 1'b0;
    tick();
    chk("bp_first_write", 32'(sb.size()), 32'd2);
    chk("bp_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_write", 32'(sb.size()), 32'd1);
    chk("bp_third_taken", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // flag masking: data written, flags unchanged (z=1,c=1 from before)
    put(16'hABCD, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mask_written", 32'(sb.size()), 32'd0);
    chk("mask_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b1010);

    // steady-state throughput, one per cycle
    for (int i = 0; i < 4; i++) begin
      put(16'h4000 + 16'(i), 3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("throughput_drained", 32'(sb.size()), 32'd0);

    // forwarding: two pending writes to r1
    wb_hold = 1'b1;
    put(16'h1234, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    put(16'h2345, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    fwd_addr_a = 3'd1; fwd_addr_b = 3'd0;
    #1;
`ifdef ALU_WB_FWD_EN
    chk("fwd_a_two", 32'({fwd_hit_a, fwd_data_a}), 32'h12345);
`else
    chk("fwd_a_two", 32'({fwd_hit_a, fwd_data_a}), 32'h00000);
`endif
    chk("fwd_b_miss", 32'({fwd_hit_b, fwd_data_b}), 32'h00000);
    wb_hold = 1'b0;
    #1;
`ifdef ALU_WB_FWD_EN
    chk("fwd_a_committing", 32'({fwd_hit_a, fwd_data_a}), 32'h12345);
`else
    chk("fwd_a_committing", 32'({fwd_hit_a, fwd_data_a}), 32'h00000);
`endif
    tick();
`ifdef ALU_WB_FWD_EN
    chk("fwd_a_one", 32'({fwd_hit_a, fwd_data_a}), 32'h12345);
`else
    chk("fwd_a_one", 32'({fwd_hit_a, fwd_data_a}), 32'h00000);
`endif
    tick();
    chk("fwd_a_empty", 32'({fwd_hit_a, fwd_data_a}), 32'h00000);
    chk("fwd_drained", 32'(sb.size()), 32'd0);

    // mid-operation reset with a full buffer and flag_c=1
    wb_hold = 1'b1;
    put(16'h5555, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    put(16'h6666, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    fwd_addr_a = 3'd2;
    chk("mid_full_ready", 32'(in_ready), 32'd0);
    chk("mid_carry_set", 32'(flag_c), 32'd1);
    clr = 1'b1; wb_hold = 1'b0;
    #1;
    chk("mid_clr_ready", 32'(in_ready), 32'd0);
    chk("mid_clr_no_write", 32'(Write_En), 32'd0);
    chk("mid_clr_no_fwd", 32'({fwd_hit_a, fwd_hit_b}), 32'd0);
    tick();
    clr = 1'b0;
    sb.delete();
    #1;
    chk("mid_after_flags", 32'({flag_z, flag_n, flag_c, flag_v, Pre_C}), 32'd0);
    chk("mid_after_ready", 32'(in_ready), 32'd1);
    chk("mid_after_empty", 32'({Write_En, Write_Addr, Write_Data}), 32'd0);
    tick();
    chk("mid_after_nowrite", 32'(Write_En), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
